// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 pins, deframes
// device-to-host frames (start, 8 data LSB first, odd parity, stop) and
// queues good scancodes in a first-word fall-through FIFO for the core.
module ps2_kbd_rx #(
  parameter int TIMEOUT = 12500,
  parameter int FIFO_AW = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       ovf_clr,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       err
);
  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [13:0]      TMO_LIM  = 14'(TIMEOUT);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic               clk_s1_q, clk_s2_q, clk_prev_q;
  logic               dat_s1_q, dat_s2_q;
  logic               fall;
  state_t             state_q, state_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         sr_q, sr_d;
  logic               par_q, par_d;
  logic [13:0]        tmo_q, tmo_d;
  logic               push, err_d, err_q;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ovf_q;
  logic               pop, full, wr_en, drop;

  // Two-flop synchronisers plus a history flop for clock edge detection;
  // idle-high reset values so leaving reset never fakes a falling edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // Frame FSM next-state: samples data only on PS/2 falling edges and aborts stalled frames.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    par_d    = par_q;
    push     = 1'b0;
    err_d    = 1'b0;
    tmo_d    = (state_q == IDLE || fall) ? 14'd0 : tmo_q + 14'd1;
    unique case (state_q)
      IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          sr_d = {dat_s2_q, sr_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = PARITY;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (dat_s2_q && (^{sr_q, par_q})) push  = 1'b1;
          else                              err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A device that stops clocking mid-frame loses the partial byte.
    if (state_q != IDLE && !fall && tmo_q == TMO_LIM) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  // Control registers of the frame FSM.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      tmo_q    <= 14'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  // Shift register and parity bit carry no reset; the FSM qualifies their use.
  always_ff @(posedge clock) begin
    sr_q  <= sr_d;
    par_q <= par_d;
  end

  // A push into a full FIFO still lands when the head is popped in the same cycle.
  assign pop   = rd & ready;
  assign full  = (cnt_q == FULL_CNT);
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wptr_q] <= sr_q;
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)   rptr_q <= rptr_q + FIFO_AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (FIFO_AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (FIFO_AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign ready    = (cnt_q != '0);
  assign data     = ready ? mem_q[rptr_q] : 8'h00;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames bit by bit (40 core
// cycles per PS/2 bit, data changed while the PS/2 clock is high).
module tb_ps2_kbd_rx;
  localparam int TIMEOUT = 12500;

  logic       clock = 1'b0;
  logic       reset_n, ps2_clk, ps2_dat, rd, ovf_clr;
  logic [7:0] data;
  logic       ready, overflow, err;

  int n_assert = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int ra, n, e0;

  ps2_kbd_rx #(.TIMEOUT(TIMEOUT), .FIFO_AW(3)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd(rd), .ovf_clr(ovf_clr), .data(data), .ready(ready),
    .overflow(overflow), .err(err)
  );

  always #20 clock = ~clock;

  // Counts cycles in which err is high.
  always @(negedge clock) if (err === 1'b1) err_seen <= err_seen + 1;

  initial begin
    #3600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nfalls bits of a frame; ra returns the sample index
  // (core cycles after the stop-bit falling edge) at which ready first rose.
  task automatic frame_tx(input logic [7:0] b, input logic bad_par, input int nfalls,
                          input logic pop_stop, output int rdy_at);
    logic [10:0] bits;
    bits   = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    rdy_at = -1;
    for (int i = 0; i < 11 && i < nfalls; i++) begin
      ps2_dat = bits[i];
      repeat (20) @(negedge clock);
      ps2_clk = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clock);
        if (i == 10 && rdy_at < 0 && ready === 1'b1) rdy_at = c;
        if (i == 10 && pop_stop && c == 2) rd = 1'b1;
        if (i == 10 && pop_stop && c == 3) rd = 1'b0;
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; rd = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_data", data, 8'h00);
    chk("reset_ready", ready, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    chk("reset_err", err, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // 1: good frame 0x1C, visible 3 cycles after the pin fall (2 sync + push)
    e0 = err_seen;
    frame_tx(8'h1C, 1'b0, 11, 1'b0, ra);
    chk("t1_ready_latency", ra, 3);
    chk("t1_data", data, 8'h1C);
    chk("t1_ready", ready, 1'b1);
    chk("t1_no_err", err_seen - e0, 0);
    pop_one();
    chk("t1_pop_ready", ready, 1'b0);
    chk("t1_pop_data", data, 8'h00);

    // 2: parity error
    e0 = err_seen;
    frame_tx(8'h1C, 1'b1, 11, 1'b0, ra);
    chk("t2_err_cycles", err_seen - e0, 1);
    chk("t2_ready", ready, 1'b0);
    chk("t2_no_push", ra, -1);

    // 3: overflow on the 9th byte
    for (int b = 1; b <= 9; b++) begin
      frame_tx(8'(b), 1'b0, 11, 1'b0, ra);
      if (b == 8) chk("t3_ovf_before", overflow, 1'b0);
    end
    chk("t3_ovf_after", overflow, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      chk("t3_pop_data", data, 32'(k));
      pop_one();
    end
    chk("t3_empty", ready, 1'b0);
    chk("t3_ovf_held", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 1'b0);

    // 4: stalled frame times out
    e0 = err_seen;
    frame_tx(8'h00, 1'b0, 5, 1'b0, ra);
    n = 24;
    while (err !== 1'b1 && n < TIMEOUT + 100) begin
      @(negedge clock);
      n++;
    end
    chk("t4_timeout_seen", err, 1'b1);
    chk("t4_timeout_window", (n >= TIMEOUT + 2 && n <= TIMEOUT + 5), 1'b1);
    @(negedge clock);
    chk("t4_err_one_cycle", err, 1'b0);
    chk("t4_no_push", ready, 1'b0);
    frame_tx(8'hF0, 1'b0, 11, 1'b0, ra);
    chk("t4_next_data", data, 8'hF0);
    chk("t4_next_ready", ready, 1'b1);
    chk("t4_err_count", err_seen - e0, 1);
    pop_one();

    // 5: push into full FIFO with a simultaneous pop
    for (int b = 0; b < 8; b++) frame_tx(8'h10 + 8'(b), 1'b0, 11, 1'b0, ra);
    chk("t5_full_cnt", dut.cnt_q, 8);
    frame_tx(8'hAA, 1'b0, 11, 1'b1, ra);
    chk("t5_no_ovf", overflow, 1'b0);
    chk("t5_cnt", dut.cnt_q, 8);
    for (int k = 1; k <= 7; k++) begin
      chk("t5_pop_data", data, 32'(8'h10 + 8'(k)));
      pop_one();
    end
    chk("t5_last_entry", data, 8'hAA);
    pop_one();
    chk("t5_empty", ready, 1'b0);

    // 6: reset mid-frame
    frame_tx(8'h77, 1'b0, 11, 1'b0, ra);
    frame_tx(8'h33, 1'b0, 6, 1'b0, ra);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("t6_rst_data", data, 8'h00);
    chk("t6_rst_ready", ready, 1'b0);
    chk("t6_rst_ovf", overflow, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    repeat (5) @(negedge clock);
    e0 = err_seen;
    frame_tx(8'h5A, 1'b0, 11, 1'b0, ra);
    chk("t6_data", data, 8'h5A);
    chk("t6_ready", ready, 1'b1);
    chk("t6_no_err", err_seen - e0, 0);
    pop_one();
    chk("t6_empty", ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
